// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator.
// Format selectors and skid-buffer FSM states.
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_RSVD  = 3'b111;

  // bit0 = M valid, bit1 = K valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b01,
    ST_FULL2 = 2'b11
  } state_t;

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational RV immediate decoder.
// instr + ImmSrc -> XLEN-bit immediate and illegal flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      ImmSrc,
  output logic [XLEN-1:0] ImmExt,
  output logic            illegal
);

  logic [31:0] imm32;
  logic        sext;
  logic        unused_op;

  assign unused_op = ^instr[6:0];

  always_comb begin
    imm32   = '0;
    sext    = 1'b1;
    illegal = 1'b0;
    unique case (ImmSrc)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25],
                      instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31],
                      instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31],
                      instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_SHAMT: begin
        sext = 1'b0;
        if (XLEN == 64)
          imm32 = {26'b0, instr[25:20]};
        else
          imm32 = {27'b0, instr[24:20]};
      end
      IMM_ZIMM: begin
        sext  = 1'b0;
        imm32 = {27'b0, instr[19:15]};
      end
      IMM_RSVD: begin
        sext    = 1'b0;
        illegal = 1'b1;
      end
      default: begin
        sext    = 1'b0;
        illegal = 1'b1;
      end
    endcase
    ImmExt = sext ? XLEN'($signed(imm32))
                  : XLEN'(imm32);
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with 2-entry skid buffer.
// M drives the outputs; K absorbs one beat of back-pressure.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic             illegal,
  output logic [TAG_W-1:0] tag_out
);

  state_t state, state_n;

  logic [XLEN-1:0]  d_imm;
  logic             d_ill;

  logic [XLEN-1:0]  m_imm, k_imm;
  logic             m_ill, k_ill;
  logic [TAG_W-1:0] m_tag, k_tag;

  logic accept;
  logic ld_m_new;
  logic ld_m_k;
  logic ld_k;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (instr),
    .ImmSrc  (ImmSrc),
    .ImmExt  (d_imm),
    .illegal (d_ill)
  );

  // Ready/valid come straight from state bits.
  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign ImmExt    = m_imm;
  assign illegal   = m_ill;
  assign tag_out   = m_tag;

  assign accept   = in_valid & in_ready;
  assign ld_m_new = accept &
                    ((state == ST_EMPTY) | out_ready);
  assign ld_k     = accept & (state == ST_FULL1) &
                    ~out_ready;
  assign ld_m_k   = (state == ST_FULL2) & out_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_EMPTY: begin
        if (accept) state_n = ST_FULL1;
      end
      ST_FULL1: begin
        if (accept && !out_ready)
          state_n = ST_FULL2;
        else if (!accept && out_ready)
          state_n = ST_EMPTY;
      end
      ST_FULL2: begin
        if (out_ready) state_n = ST_FULL1;
      end
      default: state_n = ST_EMPTY;
    endcase
    if (flush) state_n = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_imm <= '0;
      m_ill <= 1'b0;
      m_tag <= '0;
      k_imm <= '0;
      k_ill <= 1'b0;
      k_tag <= '0;
    end else if (!flush) begin
      if (ld_k) begin
        k_imm <= d_imm;
        k_ill <= d_ill;
        k_tag <= tag_in;
      end
      if (ld_m_new) begin
        m_imm <= d_imm;
        m_ill <= d_ill;
        m_tag <= tag_in;
      end else if (ld_m_k) begin
        m_imm <= k_imm;
        m_ill <= k_ill;
        m_tag <= k_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: XLEN=32 and XLEN=64
// instances in lockstep, plus skid/flush/reset sequences.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  src;
  logic [31:0] tag_in;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int checks;
  int errors;

  imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy32),
    .instr     (instr),
    .ImmSrc    (src),
    .tag_in    (tag_in),
    .out_valid (vld32),
    .out_ready (out_ready),
    .ImmExt    (imm32),
    .illegal   (ill32),
    .tag_out   (tag32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy64),
    .instr     (instr),
    .ImmSrc    (src),
    .tag_in    (tag_in),
    .out_valid (vld64),
    .out_ready (out_ready),
    .ImmExt    (imm64),
    .illegal   (ill64),
    .tag_out   (tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] instr;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] t);
    in_valid = 1'b1;
    src      = 3'b000;
    instr    = 32'h00500113;
    tag_in   = t;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    src       = '0;
    tag_in    = '0;

    vecs[0]  = '{3'b000, 32'h00500113, 32'h00000005,
                 64'h5, 1'b0};
    vecs[1]  = '{3'b001, 32'hFE512E23, 32'hFFFFFFFC,
                 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{3'b010, 32'hFE000CE3, 32'hFFFFFFF8,
                 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[3]  = '{3'b011, 32'h001000EF, 32'h00000800,
                 64'h800, 1'b0};
    vecs[4]  = '{3'b100, 32'h123452B7, 32'h12345000,
                 64'h12345000, 1'b0};
    vecs[5]  = '{3'b000, 32'hFFF00093, 32'hFFFFFFFF,
                 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[6]  = '{3'b100, 32'h800002B7, 32'h80000000,
                 64'hFFFFFFFF80000000, 1'b0};
    vecs[7]  = '{3'b101, 32'h03F01093, 32'h0000001F,
                 64'h3F, 1'b0};
    vecs[8]  = '{3'b110, 32'h000F8073, 32'h0000001F,
                 64'h1F, 1'b0};
    vecs[9]  = '{3'b111, 32'hFFFFFFFF, 32'h0,
                 64'h0, 1'b1};
    vecs[10] = '{3'b111, 32'h12345678, 32'h0,
                 64'h0, 1'b1};

    #1;
    chk("rst_vld32", 64'(vld32), 64'd0);
    chk("rst_rdy32", 64'(rdy32), 64'd1);
    chk("rst_imm32", 64'(imm32), 64'd0);
    chk("rst_ill32", 64'(ill32), 64'd0);
    chk("rst_tag32", 64'(tag32), 64'd0);
    chk("rst_imm64", imm64,      64'd0);
    #12 rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      src      = vecs[i].src;
      instr    = vecs[i].instr;
      tag_in   = 32'h100 + 32'(i);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_vld32", i), 64'(vld32), 64'd1);
      chk($sformatf("v%0d_imm32", i), 64'(imm32),
          64'(vecs[i].e32));
      chk($sformatf("v%0d_ill32", i), 64'(ill32),
          64'(vecs[i].ill));
      chk($sformatf("v%0d_tag32", i), 64'(tag32),
          64'h100 + 64'(i));
      chk($sformatf("v%0d_imm64", i), imm64, vecs[i].e64);
      chk($sformatf("v%0d_ill64", i), 64'(ill64),
          64'(vecs[i].ill));
    end
    step();
    chk("drain_vld", 64'(vld32), 64'd0);

    // back-pressure: A, B accepted, C held upstream
    out_ready = 1'b0;
    offer(32'hA);
    step();
    chk("bp_a_tag", 64'(tag32), 64'hA);
    chk("bp_a_rdy", 64'(rdy32), 64'd1);
    offer(32'hB);
    step();
    chk("bp_b_rdy", 64'(rdy32), 64'd0);
    chk("bp_b_hold", 64'(tag32), 64'hA);
    offer(32'hC);
    step();
    chk("bp_c_rdy", 64'(rdy32), 64'd0);
    chk("bp_c_hold", 64'(tag32), 64'hA);
    chk("bp_c_imm", 64'(imm32), 64'd5);
    chk("bp_c_vld", 64'(vld32), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", 64'(tag32), 64'hB);
    chk("bp_out_b_rdy", 64'(rdy32), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_c", 64'(tag32), 64'hC);
    chk("bp_out_c_vld", 64'(vld32), 64'd1);
    step();
    chk("bp_empty", 64'(vld32), 64'd0);

    // flush from FULL2 with a simultaneous offer
    out_ready = 1'b0;
    offer(32'h11);
    step();
    offer(32'h12);
    step();
    chk("fl_full2", 64'(rdy32), 64'd0);
    offer(32'h13);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_vld", 64'(vld32), 64'd0);
    chk("fl2_rdy", 64'(rdy32), 64'd1);
    out_ready = 1'b1;
    step();
    chk("fl2_none", 64'(vld32), 64'd0);

    // flush from FULL1 discards a real accept
    offer(32'h21);
    step();
    offer(32'h22);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1_vld", 64'(vld32), 64'd0);
    step();
    chk("fl1_none", 64'(vld32), 64'd0);

    // asynchronous reset in FULL2
    out_ready = 1'b0;
    offer(32'h31);
    src   = 3'b001;
    instr = 32'hFE512E23;
    step();
    offer(32'h32);
    src   = 3'b001;
    instr = 32'hFE512E23;
    step();
    in_valid = 1'b0;
    chk("ar_pre_rdy", 64'(rdy32), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", 64'(vld32), 64'd0);
    chk("ar_rdy", 64'(rdy32), 64'd1);
    chk("ar_imm", 64'(imm32), 64'd0);
    chk("ar_tag", 64'(tag32), 64'd0);
    chk("ar_imm64", imm64, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("ar_idle", 64'(vld32), 64'd0);
    offer(32'h41);
    step();
    in_valid = 1'b0;
    chk("ar_post_vld", 64'(vld32), 64'd1);
    chk("ar_post_imm", 64'(imm32), 64'd5);
    chk("ar_post_tag", 64'(tag32), 64'h41);
    step();
    chk("ar_post_drain", 64'(vld32), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
